clk_nco_gen: RTL and testbench
==============================

Name: clk_nco_gen

Overview:
- Parametrised, fully digital successor to the fixed two-output PLL wrapper: generates NUM_CLKS derived clock outputs from refclk using per-channel phase accumulators (NCOs).
- Each channel emits a square-wave outclk and a one-cycle clock-enable pulse.
- Frequency and phase are runtime-reprogrammable through a valid/ready config port.
- A settle counter drives locked; all outputs are gated while unlocked.

Parameters:
- NUM_CLKS, 2, number of output channels (1..16).
- ACC_W, 32, accumulator and increment width in bits.
- LOCK_CYCLES, 16, refclk cycles from start/reconfig to locked assertion (>=1).
- DEFAULT_INC, {32'h80000000, 32'h66666666}, packed NUM_CLKS*ACC_W reset increments; channel 0 in LSBs. At 50 MHz these give 20 MHz (ch0) and 25 MHz (ch1).

Ports:
- refclk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept.
- cfg_chan  in  4  target channel index.
- cfg_inc  in  ACC_W  new phase increment.
- cfg_phase  in  ACC_W  accumulator preload value.
- cfg_err  out  1  one-cycle pulse: rejected request.
- outclk  out  NUM_CLKS  square-wave outputs, bit i = channel i.
- clk_en  out  NUM_CLKS  one-cycle enable per accumulator wrap.
- locked  out  1  outputs valid.

Behaviour:
- Reset (rst=0, async):
  - inc[i]=DEFAULT_INC slice, acc[i]=0, settle count=0, state=SETTLE.
  - outclk=0, clk_en=0, locked=0, cfg_err=0, cfg_ready=0.
- cfg_ready=1 from the first refclk edge after rst release, except during the APPLY cycle.
- Accumulator, every edge, per channel (except the channel loaded in APPLY):
  - {carry,acc_next} = acc + inc, modulo 2^ACC_W; acc <= acc_next.
- Registered outputs:
  - outclk[i] <= acc_next[ACC_W-1] & locked_next.
  - clk_en[i] <= carry & locked_next.
  - Both are therefore forced 0 on every cycle where locked is 0.
- State machine:
  - SETTLE: counter increments each edge. On count==LOCK_CYCLES-1 -> RUN with locked<=1, so locked is first high LOCK_CYCLES edges after entry.
  - RUN: locked=1, free running.
  - APPLY: single cycle.
- Config handshake:
  - A transfer occurs on an edge with cfg_valid&cfg_ready.
  - If cfg_chan>=NUM_CLKS: cfg_err pulses for 1 cycle, no state, counter or locked change, cfg_ready stays 1.
  - Otherwise, on the next edge (APPLY): acc[chan]<=cfg_phase, inc[chan]<=cfg_inc, locked<=0, counter<=0, then -> SETTLE.
  - Other channels keep accumulating throughout.
- Increment edge cases:
  - inc=0: channel frozen, clk_en 0, outclk = MSB of preloaded phase once locked.
  - inc=2^(ACC_W-1): outclk toggles every cycle (refclk/2).
  - Any inc value is legal.
- Simultaneous events: an accepted config on the same edge the settle counter reaches terminal wins; locked stays 0 and settle restarts.
- Reset mid-operation overrides everything immediately, including APPLY; the pending config is lost.
- cfg_* inputs are ignored while cfg_ready=0.

Test Plan:
- Reset release, defaults:
  - locked=0, outclk=0, clk_en=0 for exactly 16 cycles, then locked=1.
  - outclk[1] toggles every cycle.
  - clk_en[0] gives exactly 2 pulses per 5 cycles (pattern repeats every 5).
- Reconfig:
  - cfg chan=0, inc=32'h40000000, phase=0.
  - APPLY edge: cfg_ready=0, locked=0 next cycle; locked returns 16 cycles later.
  - clk_en[0] then pulses every 4th cycle; outclk[0] period 4, 50% duty.
- Invalid channel:
  - cfg chan=2 (NUM_CLKS=2): cfg_err=1 for one cycle.
  - locked stays 1; outputs undisturbed, cycle-exact versus the golden model.
- Phase and stop:
  - ch1 inc=0, phase=32'h80000000: after relock outclk[1]=1 constant, clk_en[1]=0.
  - Second cfg with phase=0: outclk[1]=0 constant.
- Collision:
  - Valid cfg accepted on the edge the settle counter reaches 15: locked never rises; full 16-cycle settle restarts.
- Async reset:
  - Assert rst=0 between edges mid-RUN: all outputs 0 immediately.
  - Increments revert to defaults (verify 20/25 MHz patterns after relock).

Source files
------------

// File: rtl/clk_nco_gen.sv
// Multi-channel NCO clock generator: per-channel phase accumulators produce square-wave
// clocks and wrap-enable pulses, with runtime frequency/phase updates and a settle/lock timer.
module clk_nco_gen #(
  parameter int                        NUM_CLKS    = 2,
  parameter int                        ACC_W       = 32,
  parameter int                        LOCK_CYCLES = 16,
  parameter logic [NUM_CLKS*ACC_W-1:0] DEFAULT_INC = {32'h8000_0000, 32'h6666_6666}
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_chan,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic [ACC_W-1:0]    cfg_phase,
  output logic                cfg_err,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] clk_en,
  output logic                locked
);

  localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_APPLY  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                locked_nx, cfg_ready_nx, cfg_err_nx;
  logic                xfer, chan_ok, accept, reject;

  logic [3:0]          pend_chan;
  logic [ACC_W-1:0]    pend_inc, pend_phase;

  logic [ACC_W-1:0]    acc    [NUM_CLKS];
  logic [ACC_W-1:0]    inc    [NUM_CLKS];
  logic [ACC_W-1:0]    acc_nx [NUM_CLKS];
  logic [ACC_W-1:0]    inc_nx [NUM_CLKS];
  logic [NUM_CLKS-1:0] carry, outclk_nx, clk_en_nx;

  assign xfer    = cfg_valid & cfg_ready;
  assign chan_ok = (int'(cfg_chan) < NUM_CLKS);
  assign accept  = xfer & chan_ok;
  assign reject  = xfer & ~chan_ok;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state <= ST_SETTLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every combinational output gets a default before any branch, otherwise an
  // unassigned path infers a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_SETTLE: begin
        cnt_nx = cnt + 1'b1;
        // A config landing on the terminal count wins: settling restarts after APPLY.
        if (accept)                state_nx = ST_APPLY;
        else if (cnt == LAST_CNT)  state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (accept) state_nx = ST_APPLY;
      end
      ST_APPLY: begin
        state_nx = ST_SETTLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = ST_SETTLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Locked holds its value through the APPLY cycle and drops on the edge that loads the channel.
  always_comb begin
    locked_nx    = 1'b0;
    cfg_ready_nx = (state_nx != ST_APPLY);
    cfg_err_nx   = reject;
    case (state_nx)
      ST_RUN:   locked_nx = 1'b1;
      ST_APPLY: locked_nx = locked;
      default:  locked_nx = 1'b0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CLKS; i++) begin
      {carry[i], acc_nx[i]} = {1'b0, acc[i]} + {1'b0, inc[i]};
      inc_nx[i] = inc[i];
      if (state == ST_APPLY && pend_chan == 4'(i)) begin
        acc_nx[i] = pend_phase;
        inc_nx[i] = pend_inc;
        carry[i]  = 1'b0;
      end
      outclk_nx[i] = acc_nx[i][ACC_W-1] & locked_nx;
      clk_en_nx[i] = carry[i] & locked_nx;
    end
  end

  // NOTE: the accumulator and increment arrays are real state that defines the output
  // frequencies after reset, so they are reset like any other register.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        acc[i] <= '0;
        inc[i] <= DEFAULT_INC[i*ACC_W +: ACC_W];
      end
      outclk     <= '0;
      clk_en     <= '0;
      locked     <= 1'b0;
      cfg_ready  <= 1'b0;
      cfg_err    <= 1'b0;
      pend_chan  <= '0;
      pend_inc   <= '0;
      pend_phase <= '0;
    end else begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        acc[i] <= acc_nx[i];
        inc[i] <= inc_nx[i];
      end
      outclk    <= outclk_nx;
      clk_en    <= clk_en_nx;
      locked    <= locked_nx;
      cfg_ready <= cfg_ready_nx;
      cfg_err   <= cfg_err_nx;
      if (accept) begin
        pend_chan  <= cfg_chan;
        pend_inc   <= cfg_inc;
        pend_phase <= cfg_phase;
      end
    end
  end

endmodule

// File: tb/tb_clk_nco_gen.sv
// Testbench for clk_nco_gen: a cycle model feeds a scoreboard queue checked by a monitor,
// plus directed checks against hand-derived output patterns.
`timescale 1ns/1ps
module tb_clk_nco_gen;

  logic        refclk    = 1'b0;
  logic        rst       = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [3:0]  cfg_chan  = '0;
  logic [31:0] cfg_inc   = '0;
  logic [31:0] cfg_phase = '0;
  logic        cfg_ready, cfg_err, locked;
  logic [1:0]  outclk, clk_en;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  clk_nco_gen #(
    .NUM_CLKS    (2),
    .ACC_W       (32),
    .LOCK_CYCLES (16),
    .DEFAULT_INC ({32'h8000_0000, 32'h6666_6666})
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .cfg_err   (cfg_err),
    .outclk    (outclk),
    .clk_en    (clk_en),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  // Edges since the last reset release.
  always @(posedge refclk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct packed {
    logic       locked;
    logic       cfg_ready;
    logic       cfg_err;
    logic [1:0] outclk;
    logic [1:0] clk_en;
  } obs_t;

  typedef enum int {M_SETTLE, M_RUN, M_APPLY} mmode_t;

  obs_t        exp_q [$];
  obs_t        e_out, sb_exp, sb_act;
  mmode_t      m_mode, m_nmode;
  int          m_left;
  logic        m_locked, m_ready, m_nlock, m_take, m_good, m_wrap;
  logic [31:0] m_acc [2];
  logic [31:0] m_inc [2];
  logic [3:0]  p_chan;
  logic [31:0] p_inc, p_phase;
  logic [32:0] m_sum;

  // Reference model: counts down the edges left before lock.
  always @(posedge refclk or negedge rst) begin
    if (!rst) begin
      m_acc[0] = 32'h0;
      m_acc[1] = 32'h0;
      m_inc[0] = 32'h6666_6666;
      m_inc[1] = 32'h8000_0000;
      m_mode   = M_SETTLE;
      m_left   = 16;
      m_locked = 1'b0;
      m_ready  = 1'b0;
      exp_q.delete();
    end else begin
      m_take = cfg_valid && m_ready;
      m_good = m_take && (cfg_chan < 4'd2);
      if (m_mode == M_APPLY) begin
        m_nmode = M_SETTLE;
        m_left  = 16;
        m_nlock = 1'b0;
      end else if (m_good) begin
        m_nmode = M_APPLY;
        m_nlock = m_locked;
      end else if (m_mode == M_SETTLE) begin
        m_left  = m_left - 1;
        m_nlock = (m_left == 0);
        m_nmode = m_nlock ? M_RUN : M_SETTLE;
      end else begin
        m_nmode = M_RUN;
        m_nlock = 1'b1;
      end
      for (int c = 0; c < 2; c++) begin
        if (m_mode == M_APPLY && int'(p_chan) == c) begin
          m_acc[c] = p_phase;
          m_inc[c] = p_inc;
          m_wrap   = 1'b0;
        end else begin
          m_sum    = {1'b0, m_acc[c]} + {1'b0, m_inc[c]};
          m_acc[c] = m_sum[31:0];
          m_wrap   = m_sum[32];
        end
        e_out.outclk[c] = m_acc[c][31] & m_nlock;
        e_out.clk_en[c] = m_wrap & m_nlock;
      end
      e_out.cfg_err   = m_take && !m_good;
      e_out.cfg_ready = (m_nmode != M_APPLY);
      e_out.locked    = m_nlock;
      if (m_good) begin
        p_chan  = cfg_chan;
        p_inc   = cfg_inc;
        p_phase = cfg_phase;
      end
      m_mode   = m_nmode;
      m_locked = m_nlock;
      m_ready  = e_out.cfg_ready;
      exp_q.push_back(e_out);
    end
  end

  always @(negedge refclk) begin
    if (rst && exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      sb_act = {locked, cfg_ready, cfg_err, outclk, clk_en};
      n_cmp++;
      if (sb_act !== sb_exp) begin
        n_bad++;
        $display("FAIL scoreboard cyc=%0d got lk/rdy/err/oc/en=%b expected=%b",
                 cyc, sb_act, sb_exp);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic send_cfg(input logic [3:0] ch, input logic [31:0] inc,
                          input logic [31:0] ph, output int t_edge);
    int n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge refclk);
      n++;
    end
    check("cfg_ready_before_send", 64'(cfg_ready), 64'd1);
    cfg_chan  = ch;
    cfg_inc   = inc;
    cfg_phase = ph;
    cfg_valid = 1'b1;
    @(posedge refclk);
    #1;
    cfg_valid = 1'b0;
    t_edge    = cyc;
  endtask

  task automatic wait_lock(output int n, output logic quiet);
    n     = 0;
    quiet = 1'b1;
    do begin
      @(negedge refclk);
      n++;
      if (!locked && (outclk != 2'b00 || clk_en != 2'b00)) quiet = 1'b0;
    end while (!locked && n < 100);
  endtask

  // Defaults: ch1 = refclk/2; ch0 wraps on edges k%5 in {1,3}, MSB set on even k%5.
  task automatic check_default(input int n);
    repeat (n) begin
      check("dflt_outclk1", 64'(outclk[1]), 64'(cyc % 2));
      check("dflt_clk_en0", 64'(clk_en[0]), 64'((cyc % 5 == 1) || (cyc % 5 == 3)));
      check("dflt_outclk0", 64'(outclk[0]), 64'((cyc % 5) % 2 == 0));
      @(negedge refclk);
    end
  endtask

  initial begin
    int   n, t, a_edge, k, guard;
    logic quiet, early;

    #2;
    check("rst_outputs", 64'({locked, cfg_ready, cfg_err, outclk, clk_en}), 64'd0);
    #30;
    rst = 1'b1;

    wait_lock(n, quiet);
    check("lock_after_reset", 64'(n), 64'd16);
    check("gated_while_unlocked", 64'(quiet), 64'd1);
    check_default(10);

    // Retune ch0 to refclk/4.
    send_cfg(4'd0, 32'h4000_0000, 32'h0, t);
    a_edge = t + 1;
    @(negedge refclk);
    check("apply_cycle_ready", 64'(cfg_ready), 64'd0);
    check("apply_cycle_locked", 64'(locked), 64'd1);
    @(negedge refclk);
    check("after_apply_locked", 64'(locked), 64'd0);
    check("after_apply_ready", 64'(cfg_ready), 64'd1);
    wait_lock(n, quiet);
    check("relock_after_cfg", 64'(n), 64'd16);
    check("gated_during_settle", 64'(quiet), 64'd1);
    for (int j = 0; j < 8; j++) begin
      k = cyc - a_edge;
      check("div4_clk_en0", 64'(clk_en[0]), 64'(k % 4 == 0));
      check("div4_outclk0", 64'(outclk[0]), 64'(k % 4 >= 2));
      check("ch1_still_toggling", 64'(outclk[1]), 64'(cyc % 2));
      @(negedge refclk);
    end

    // Out-of-range channels are rejected without disturbing lock.
    send_cfg(4'd2, 32'hDEAD_BEEF, 32'h1, t);
    @(negedge refclk);
    check("bad_chan_err", 64'(cfg_err), 64'd1);
    check("bad_chan_locked", 64'(locked), 64'd1);
    check("bad_chan_ready", 64'(cfg_ready), 64'd1);
    @(negedge refclk);
    check("bad_chan_err_pulse", 64'(cfg_err), 64'd0);
    check("bad_chan_still_locked", 64'(locked), 64'd1);
    send_cfg(4'hF, 32'h1, 32'h1, t);
    @(negedge refclk);
    check("chan15_err", 64'(cfg_err), 64'd1);
    @(negedge refclk);

    // Freeze ch1 with MSB preloaded high, then low.
    send_cfg(4'd1, 32'h0, 32'h8000_0000, t);
    @(negedge refclk);
    @(negedge refclk);
    check("stop_hi_unlocked", 64'(locked), 64'd0);
    wait_lock(n, quiet);
    check("stop_hi_relock", 64'(n), 64'd16);
    repeat (6) begin
      check("stop_hi_outclk1", 64'(outclk[1]), 64'd1);
      check("stop_hi_clk_en1", 64'(clk_en[1]), 64'd0);
      @(negedge refclk);
    end
    send_cfg(4'd1, 32'h0, 32'h0, t);
    @(negedge refclk);
    @(negedge refclk);
    wait_lock(n, quiet);
    check("stop_lo_relock", 64'(n), 64'd16);
    repeat (6) begin
      check("stop_lo_outclk1", 64'(outclk[1]), 64'd0);
      check("stop_lo_clk_en1", 64'(clk_en[1]), 64'd0);
      @(negedge refclk);
    end

    // Collision: second config accepted on the edge that would have raised locked.
    send_cfg(4'd1, 32'h4000_0000, 32'h0, t);
    a_edge = t + 1;
    @(negedge refclk);
    @(negedge refclk);
    early = 1'b0;
    guard = 0;
    while (cyc < a_edge + 15 && guard < 50) begin
      if (locked) early = 1'b1;
      @(negedge refclk);
      guard++;
    end
    if (locked) early = 1'b1;
    check("collision_no_early_lock", 64'(early), 64'd0);
    send_cfg(4'd0, 32'h2000_0000, 32'h1234_5678, t);
    @(negedge refclk);
    check("collision_locked_low", 64'(locked), 64'd0);
    check("collision_apply_ready", 64'(cfg_ready), 64'd0);
    @(negedge refclk);
    check("collision_after_apply", 64'(locked), 64'd0);
    wait_lock(n, quiet);
    check("collision_full_resettle", 64'(n), 64'd16);

    // Async reset mid-run, between edges.
    repeat (5) @(negedge refclk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_outputs", 64'({locked, cfg_ready, cfg_err, outclk, clk_en}), 64'd0);
    @(negedge refclk);
    #2;
    rst = 1'b1;
    wait_lock(n, quiet);
    check("lock_after_async_rst", 64'(n), 64'd16);
    check_default(10);

    @(negedge refclk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
